// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder serial engine.
// Holds the default character length, the FSM state encoding and the
// helper that maps the len port onto an effective bit count.
package spi_slave_pkg;

  localparam int CHAR_LEN_DEF = 32;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t ACTIVE = 1'b1;

  // len == 0 encodes a full-width character.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned char_len);
    return (len == 0) ? char_len : len;
  endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Parallel-side bus of the SPI responder.
//   tx_data/tx_valid/tx_ready : holding-register handshake for the next word
//   rx_data/rx_valid          : last received word and its one-cycle strobe
//   tx_underrun               : one-cycle strobe, character started with no word queued
// Modport slave is the engine side, master is the host side.
interface spi_slave_shifter_if
  import spi_slave_pkg::*;
#(
  parameter int CHAR_LEN = CHAR_LEN_DEF
);
  logic [CHAR_LEN-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [CHAR_LEN-1:0] rx_data;
  logic                rx_valid;
  logic                tx_underrun;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun
  );
endinterface

// File: rtl/spi_pad_sync.sv
// Brings the asynchronous SPI pads into the clk_in domain and derives edges.
// Ports:
//   clk_in, rst                 : system clock, async active-high reset
//   sclk_pad, cs_n_pad, mosi_pad: raw pads
//   cpol                        : clock idle level
//   lead_edge, trail_edge       : synced sclk left / returned to idle level
//   cs_fall, cs_rise            : synced chip-select transitions
//   mosi_s                      : synced MOSI
module spi_pad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sclk_pad,
  input  logic cs_n_pad,
  input  logic mosi_pad,
  input  logic cpol,
  output logic lead_edge,
  output logic trail_edge,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic                   sclk_h, cs_h;

  // sclk is folded with cpol before synchronizing, so the chain always idles
  // at 0 and resets to the idle level regardless of mode. cpol only changes
  // in IDLE, where any resulting spurious edge is ignored.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_h <= 1'b0;
      cs_h   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_pad ^ cpol};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n_pad};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_pad};
      sclk_h <= sclk_q[SYNC_STAGES-1];
      cs_h   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign lead_edge  =  sclk_q[SYNC_STAGES-1] & ~sclk_h;
  assign trail_edge = ~sclk_q[SYNC_STAGES-1] &  sclk_h;
  assign cs_fall    = ~cs_q[SYNC_STAGES-1]   &  cs_h;
  assign cs_rise    =  cs_q[SYNC_STAGES-1]   & ~cs_h;
  assign mosi_s     =  mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave_shifter.sv
// SPI responder serial engine: oversamples SCLK/CS_n/MOSI in clk_in, shifts
// variable-length characters in on MOSI and out on MISO in all CPOL/CPHA modes.
// Ports:
//   clk_in, rst          : system clock, async active-high reset
//   sclk_pad/cs_n_pad/mosi_pad, miso_pad/miso_oe : SPI pads
//   cpol, cpha, len      : mode and character length (len 0 = CHAR_LEN bits)
//   bus (slave modport)  : tx holding handshake, rx word/strobe, underrun strobe
//   busy                 : FSM in ACTIVE
// Build option: SPI_SLAVE_LSB_EN adds input lsb (LSB-first tx/rx, sampled at load).
//
// state  | meaning
// IDLE   | deselected, MISO tri-stated, waiting for cs_n to fall
// ACTIVE | selected, shifting characters on sclk edges
module spi_slave_shifter
  import spi_slave_pkg::*;
#(
  parameter int CHAR_LEN    = CHAR_LEN_DEF,
  parameter int LEN_W       = $clog2(CHAR_LEN),
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sclk_pad,
  input  logic             cs_n_pad,
  input  logic             mosi_pad,
  output logic             miso_pad,
  output logic             miso_oe,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [LEN_W-1:0] len,
`ifdef SPI_SLAVE_LSB_EN
  input  logic             lsb,
`endif
  spi_slave_shifter_if.slave bus,
  output logic             busy
);
  localparam int EW = LEN_W + 1;

  state_t              state;
  logic                lead_edge, trail_edge, cs_fall, cs_rise, mosi_s;
  logic                sample_edge, drive_edge;
  logic                accept, done, load, underrun_now;
  logic                lsb_sel, lsb_q;
  logic                hold_full, rx_pend, rx_valid_q, underrun_q;
  logic [CHAR_LEN-1:0] hold_data, load_word, tx_shift, rx_shift, rx_data_q;
  logic [CHAR_LEN-1:0] rx_next, rx_just, tx_adv, ld_adv;
  logic                tx_bit, ld_bit;
  logic [EW-1:0]       eff, bit_cnt;

  spi_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pad_sync (
    .clk_in     (clk_in),
    .rst        (rst),
    .sclk_pad   (sclk_pad),
    .cs_n_pad   (cs_n_pad),
    .mosi_pad   (mosi_pad),
    .cpol       (cpol),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .mosi_s     (mosi_s)
  );

`ifdef SPI_SLAVE_LSB_EN
  assign lsb_sel = lsb;
`else
  assign lsb_sel = 1'b0;
`endif

  assign eff         = EW'(eff_len(32'(len), CHAR_LEN));
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge  : trail_edge;

  assign accept       = bus.tx_valid & ~hold_full;
  assign done         = (state == ACTIVE) && (bit_cnt == eff);
  // A completed character still reports even if cs_n rises alongside it,
  // but no further word is loaded once the master has deselected.
  assign load         = ((state == IDLE) & cs_fall) | (done & ~cs_rise);
  assign load_word    = accept ? bus.tx_data : (hold_full ? hold_data : '0);
  assign underrun_now = load & ~accept & ~hold_full;

  always_comb begin
    rx_next = lsb_q ? {mosi_s, rx_shift[CHAR_LEN-1:1]} : {rx_shift[CHAR_LEN-2:0], mosi_s};
    // LSB-first characters fill from the top, so bring them down to bit 0.
    rx_just = lsb_q ? (rx_shift >> (EW'(CHAR_LEN) - eff)) : rx_shift;
    tx_bit  = lsb_q ? tx_shift[0] : tx_shift[CHAR_LEN-1];
    tx_adv  = lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
    ld_bit  = lsb_sel ? load_word[0] : load_word[CHAR_LEN-1];
    ld_adv  = lsb_sel ? (load_word >> 1) : (load_word << 1);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      lsb_q      <= 1'b0;
      miso_pad   <= 1'b0;
      miso_oe    <= 1'b0;
      rx_data_q  <= '0;
      rx_pend    <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_pend    <= done;
      rx_valid_q <= rx_pend;
      underrun_q <= underrun_now;

      if (load)
        hold_full <= 1'b0;
      else if (accept) begin
        hold_full <= 1'b1;
        hold_data <= bus.tx_data;
      end

      if (state == IDLE) begin
        if (cs_fall) begin
          state   <= ACTIVE;
          miso_oe <= 1'b1;
        end
      end else begin
        if (done)
          rx_data_q <= rx_just;
        if (cs_rise) begin
          state    <= IDLE;
          miso_oe  <= 1'b0;
          miso_pad <= 1'b0;
          bit_cnt  <= '0;
        end else if (!done) begin
          if (sample_edge) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + EW'(1);
          end
          // In cpha=0 the bit was already presented at load; the trailing
          // edge that closes the previous character (bit_cnt==0) is skipped.
          if (drive_edge && (cpha || bit_cnt != '0)) begin
            miso_pad <= tx_bit;
            tx_shift <= tx_adv;
          end
        end
      end

      if (load) begin
        lsb_q    <= lsb_sel;
        rx_shift <= '0;
        bit_cnt  <= '0;
        if (cpha)
          tx_shift <= load_word;
        else begin
          tx_shift <= ld_adv;
          miso_pad <= ld_bit;
        end
      end
    end
  end

  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign busy            = (state == ACTIVE);
endmodule
